// File: rtl/proc_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states
// and fetch-related constants.
package proc_pkg;
    localparam int          INSTR_W          = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DELIVER
    } fetch_state_t;
endpackage

// File: rtl/perf_counter.sv
// Free-running event counter; wraps at 2^W. Shared by the pipeline stages
// that report performance statistics.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: owns the PC, issues one instruction-memory read at a
// time and hands fetched words to decode, honouring stalls and redirects.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               misalign,
    output logic [31:0]        fetch_count
);
    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] target;
    logic              squash;
    logic              redir;
    logic              consume;

    // Stall wins over a redirect; IDLE is the post-reset settling cycle.
    assign redir    = br_taken & ~if_stall & (state != IDLE);
    assign target   = {br_target[ADDR_W-1:2], 2'b00};
    assign consume  = (state == DELIVER) & ~if_stall & ~br_taken;
    assign misalign = redir & (br_target[1:0] != 2'b00);

    assign imem_req  = (state == REQ);
    assign imem_addr = (state == REQ) ? pc : '0;
    assign if_valid  = (state == DELIVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            squash      <= 1'b0;
            if_pc       <= '0;
            if_instr    <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_gnt) begin
                        inflight_pc <= pc;
                        state       <= WAIT;
                        if (redir) begin
                            squash <= 1'b1;
                            pc     <= target;
                        end
                    end else if (redir) begin
                        pc <= target;
                    end
                end
                WAIT: begin
                    if (redir) begin
                        pc <= target;
                    end
                    // A redirect in the same cycle as the data also kills it.
                    if (imem_rvalid) begin
                        if (squash | redir) begin
                            squash <= 1'b0;
                            state  <= REQ;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= inflight_pc;
                            pc       <= inflight_pc + ADDR_W'(PC_STEP);
                            state    <= DELIVER;
                        end
                    end else if (redir) begin
                        squash <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (redir) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (consume) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    perf_counter #(.W(32)) u_fetch_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (consume),
        .count (fetch_count)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a random-latency memory
// model, random stalls/redirects, and a monitor checking each delivery.
module tb_fetch_sequencer;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        misalign;
    logic [31:0] fetch_count;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_stall(if_stall), .br_taken(br_taken), .br_target(br_target),
        .misalign(misalign), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] model_count;
    logic        mem_hold = 1'b0;
    logic        late_inj = 1'b0;
    logic        mem_pending = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'd2654435761 + 32'h0001_3579;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur_pc      = RST_PC;
        model_count = '0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
    endtask

    // Memory: grants at random, returns memf(addr) 1..3 cycles after grant.
    initial begin
        logic        fire;
        int          cnt;
        logic [31:0] paddr;
        fire = 1'b0; cnt = 0; paddr = '0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                mem_pending = 1'b0; fire = 1'b0; imem_gnt = 1'b0;
                continue;
            end
            if (fire) begin
                mem_pending = 1'b1; cnt = $urandom_range(0, 2); fire = 1'b0;
            end
            if (late_inj) begin
                imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
                imem_gnt = 1'b0; late_inj = 1'b0;
                continue;
            end
            if (mem_pending && !mem_hold) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1; imem_rdata = memf(paddr); mem_pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_gnt = imem_req && !mem_pending && ($urandom_range(0, 2) != 0);
            if (imem_gnt) begin
                fire = 1'b1; paddr = imem_addr;
            end
        end
    end

    // Monitor: pops the expected PC on each new delivery, checks it is held while stalled.
    initial begin
        logic        prev_valid;
        logic [31:0] held, e;
        prev_valid = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (if_valid && !prev_valid) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", if_pc, 32'hFFFF_FFFF);
                    held = if_pc;
                end else begin
                    e = exp_q.pop_front();
                    held = e;
                    chk("deliver_pc", if_pc, e);
                    chk("deliver_instr", if_instr, memf(e));
                    chk("deliver_count", fetch_count, model_count);
                end
            end else if (if_valid && prev_valid) begin
                chk("held_pc", if_pc, held);
                chk("held_instr", if_instr, memf(held));
                chk("held_count", fetch_count, model_count);
            end
            prev_valid = if_valid;
        end
    end

    // One cycle of decode-side stimulus; the model is updated at the edge it takes effect.
    task automatic step(input logic s, input logic b, input logic [31:0] t, output logic v);
        if_stall = s; br_taken = b; br_target = t;
        @(negedge clk);
        v = if_valid;
        chk("misalign", 32'(misalign), 32'(b && !s && (t[1:0] != 2'b00)));
        if (v) chk("req_in_deliver", 32'(imem_req), 32'd0);
        @(posedge clk);
        if (b && !s) begin
            cur_pc = {t[31:2], 2'b00};
            exp_q.delete(); exp_q.push_back(cur_pc);
        end else if (v && !s && !b) begin
            cur_pc = cur_pc + 32'd4;
            model_count = model_count + 32'd1;
            exp_q.delete(); exp_q.push_back(cur_pc);
        end
        #2;
    endtask

    task automatic drain();
        int   start;
        logic v;
        start = n_deliv;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, '0, v);
            if (n_deliv != start) return;
        end
        chk("drain_timeout", 32'(n_deliv - start), 32'd1);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_0000;
            1:       base = 32'h0000_0100;
            default: base = 32'hFFFF_FFF0;
        endcase
        return base + 32'($urandom_range(0, 15));
    endfunction

    initial begin
        logic v;
        model_reset();
        #3;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Free-running fetch through the address wrap.
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '0, v);

        // Hold a delivered instruction under stall; redirects must be ignored.
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, '0, v);
            if (v) break;
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h0000_0200, v);
        drain();

        // Misaligned redirect to 0x103 must fetch from 0x100.
        step(1'b0, 1'b1, 32'h0000_0103, v);
        drain();

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, rand_target(), v);
        end
        drain();
        chk("count_after_random", fetch_count, model_count);

        // Reset in WAIT: outputs clear at once, late rvalid after release is ignored.
        mem_hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, '0, v);
            if (mem_pending) break;
        end
        chk("reached_wait", 32'(mem_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_instr", if_instr, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        @(posedge clk); @(negedge clk);
        model_reset();
        mem_hold = 1'b0;
        late_inj = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1, rand_target(), v);
        end
        drain();
        chk("final_count", fetch_count, model_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that owns the program counter and sequences instruction-memory reads for the IF stage.
- Issues requests over a req/gnt/rvalid handshake and presents one fetched instruction at a time to decode.
- Honours hazard stalls from the hazard unit and branch redirects resolved in decode.
- Squashes wrong-path fetches that are already in flight.

Parameters:
ADDR_W, 32, width of PC and instruction address
RESET_PC, 32'h0000_0000, first fetch address after reset (low 2 bits must be 0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, word aligned
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_pc  out  ADDR_W  address of if_instr
if_instr  out  32  fetched instruction
if_stall  in  1  hazard detected; decode not accepting
br_taken  in  1  branch redirect from decode
br_target  in  ADDR_W  redirect target
misalign  out  1  one-cycle pulse: accepted br_target had nonzero [1:0]
fetch_count  out  32  count of instructions consumed by decode

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, squash=0.
  - All outputs 0 (imem_addr=0, if_pc=0, if_instr=0, fetch_count=0).
  - Asserting rst_n=0 mid-transaction abandons it; any rvalid arriving after reset release while in IDLE/REQ is ignored.
- Accepted redirect: redir = br_taken & ~if_stall. br_taken is ignored whenever if_stall=1; stall has priority.
- Target alignment: target = {br_target[ADDR_W-1:2],2'b00}. misalign=1 in the cycle a redir is accepted with br_target[1:0]!=0.
- IDLE: the first cycle after reset release goes to REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - redir & ~gnt: pc=target, stay REQ; the address may change because the old request was not granted.
  - gnt & ~redir: inflight_pc=pc, go WAIT.
  - gnt & redir: inflight_pc=pc, squash=1, pc=target, go WAIT.
- WAIT:
  - imem_req=0.
  - redir: squash=1, pc=target.
  - rvalid & squash (set earlier or this cycle): drop data, squash=0, go REQ.
  - rvalid & ~squash: if_instr=rdata, if_pc=inflight_pc, pc=inflight_pc+4, go DELIVER.
- DELIVER:
  - if_valid=1; outputs held stable while if_stall=1.
  - ~if_stall & ~br_taken: consumed; fetch_count+=1, go REQ.
  - redir: held instruction is wrong-path; drop it, if_valid=0 next cycle, pc=target, go REQ, fetch_count unchanged.
- if_valid is 1 only in DELIVER.
- imem_rvalid outside WAIT is ignored.
- Only one request is outstanding at a time.
- PC arithmetic: pc+4 modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0. fetch_count wraps at 2^32.
- Latency: with gnt in the request cycle and rvalid one cycle later, REQ→WAIT→DELIVER gives if_valid 2 cycles after imem_req first asserts. Steady-state throughput is 1 instruction per 3 cycles.
- Extra memory wait cycles extend REQ (no gnt) or WAIT (no rvalid) indefinitely; no timeout.

Decomposition:
- Shared package (proc_pkg): state enum {IDLE,REQ,WAIT,DELIVER}, INSTR_W=32, PC_STEP=4, default RESET_PC.
- No sub-module is needed. The 32-bit fetch_count may be factored as a small perf_counter, reused by other stages.

Test Plan:
- Reset release, memory with 1-cycle gnt and rvalid next cycle returning 0x11,0x22,0x33 → if_pc 0x0,0x4,0x8 with matching if_instr, if_valid every 3rd cycle, fetch_count=3.
- Hold if_stall=1 for 4 cycles while in DELIVER at pc=0x4 → if_pc/if_instr stable, fetch_count unchanged, imem_req=0 throughout; on release the next request addr is 0x8.
- br_taken=1, br_target=0x100 in the same cycle as gnt for addr 0x8 → returned data dropped, next imem_addr=0x100, and the first if_pc after that is 0x100.
- br_taken=1 with if_stall=1 → ignored, pc unchanged. br_target=0x103 with if_stall=0 → misalign pulse, fetch from 0x100.
- RESET_PC=0xFFFF_FFFC → second fetch addr 0x0. rst_n pulled low during WAIT → outputs 0 immediately; late rvalid after release is ignored and the next fetch starts at RESET_PC.
